// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: accepts one decoded memory op at a time, runs the
// data-bus request/grant/response handshake, steers byte lanes and extends load data.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        ex_ready,
  output logic        lsu_busy,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign_err,
  output logic [31:0] err_addr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t      state, state_next;
  logic        op_is_load;
  logic        discard, discard_d;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic [4:0]  op_rd;
  logic        req_d, busy_d, wb_valid_d;

  // Accept-time decode: flush in IDLE suppresses both the accept and the fault.
  logic accept_cycle, op_one_hot, funct3_ok, aligned, op_legal, accept, fault;
  assign accept_cycle = (state == IDLE) & ex_valid & ~flush;
  assign op_one_hot   = ex_is_load ^ ex_is_store;
  assign funct3_ok    = ex_is_store ? (ex_funct3 inside {3'b000, 3'b001, 3'b010})
                                    : (ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign aligned      = (ex_funct3[1:0] == 2'b01) ? ~ex_addr[0] :
                        (ex_funct3[1:0] == 2'b10) ? (ex_addr[1:0] == 2'b00) : 1'b1;
  assign op_legal     = op_one_hot & funct3_ok & aligned;
  assign accept       = accept_cycle & op_legal;
  assign fault        = accept_cycle & ~op_legal;

  assign ex_ready = (state == IDLE);

  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_result;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << ex_addr[1:0];
        st_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        st_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte     = mem_rdata[{ld_offset, 3'b000} +: 8];
    rd_half     = mem_rdata[{ld_offset[1], 4'b0000} +: 16];
    load_result = mem_rdata;
    case (ld_funct3)
      3'b000:  load_result = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  load_result = {24'h0, rd_byte};
      3'b001:  load_result = {{16{rd_half[15]}}, rd_half};
      3'b101:  load_result = {16'h0, rd_half};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (accept) state_next = REQ;
      REQ:    if (mem_gnt) state_next = op_is_load ? WAIT_R : IDLE;
              else if (flush) state_next = IDLE;
      WAIT_R: if (mem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A grant seen together with flush still commits the bus transfer; only the load writeback is dropped.
  always_comb begin
    req_d      = (state_next == REQ);
    busy_d     = (state_next != IDLE);
    wb_valid_d = (state == WAIT_R) & mem_rvalid & ~discard & ~flush;
    discard_d  = discard;
    if (accept)
      discard_d = 1'b0;
    else if (flush & (((state == REQ) & mem_gnt & op_is_load) | (state == WAIT_R)))
      discard_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wstrb    <= '0;
      mem_wdata    <= '0;
      lsu_busy     <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
      discard      <= 1'b0;
      op_is_load   <= 1'b0;
      ld_funct3    <= '0;
      ld_offset    <= '0;
      op_rd        <= '0;
    end else begin
      mem_req      <= req_d;
      lsu_busy     <= busy_d;
      wb_valid     <= wb_valid_d;
      misalign_err <= fault;
      discard      <= discard_d;
      if (accept) begin
        mem_we     <= ex_is_store;
        mem_addr   <= {ex_addr[31:2], 2'b00};
        mem_wstrb  <= ex_is_store ? st_wstrb : 4'b0000;
        mem_wdata  <= ex_is_store ? st_wdata : 32'h0;
        op_is_load <= ex_is_load;
        ld_funct3  <= ex_funct3;
        ld_offset  <= ex_addr[1:0];
        op_rd      <= ex_rd;
      end
      if (fault)
        err_addr <= ex_addr;
      if (wb_valid_d) begin
        wb_data <= load_result;
        wb_rd   <= op_rd;
      end
    end
  end

endmodule
